// File: rtl/dec_seq_pkg.sv
// Shared types and constants for the dec_seq one-hot decoder/sweeper.
// The SWEEP state only exists when DEC_SEQ_SWEEP_EN is defined.
package dec_seq_pkg;

  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1
`ifdef DEC_SEQ_SWEEP_EN
    ,
    SWEEP = 2'd2
`endif
  } state_e;

endpackage

// File: rtl/dec_seq_if.sv
// Request/response bundle between a requester (master) and dec_seq (slave).
interface dec_seq_if #(
  parameter int IN_W = 4
);
  localparam int OUT_W = 2 ** IN_W;

  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in;
  logic             sweep;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output en, in_valid, in, sweep,
    input  in_ready, out, out_valid, busy, done
  );

  modport slave (
    input  en, in_valid, in, sweep,
    output in_ready, out, out_valid, busy, done
  );
endinterface

// File: rtl/dec_hold_timer.sv
// Reloadable down-counter that pulses expire on the enabled cycle its count is zero.
module dec_hold_timer
  import dec_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              enable,
  input  logic [HOLD_W-1:0] load_val,
  output logic              expire
);

  logic [HOLD_W-1:0] cnt_r;

  assign expire = enable && !load && (cnt_r == {HOLD_W{1'b0}});

  // Count register: load wins, then reload on expiry, otherwise count down while enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {HOLD_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (enable) begin
      if (cnt_r == {HOLD_W{1'b0}}) begin
        cnt_r <= load_val;
      end else begin
        cnt_r <= cnt_r - {{(HOLD_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/dec_seq.sv
// One-hot decoder with optional timed sweep (enabled by macro DEC_SEQ_SWEEP_EN).
// en low freezes all state and blanks out/out_valid.
module dec_seq
  import dec_seq_pkg::*;
#(
  parameter int IN_W     = 4,
  parameter int HOLD_CYC = 1
) (
  input logic     clk,
  input logic     rst,
  dec_seq_if.slave bus
);

  localparam int OUT_W = 2 ** IN_W;
  localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

  state_e           state_r, state_s;
  logic [OUT_W-1:0] out_r, out_s;
  logic             ready_r;
  logic             accept_s;

`ifdef DEC_SEQ_SWEEP_EN
  localparam logic [IN_W-1:0]   LAST    = IN_W'(OUT_W - 1);
  localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_CYC - 1);

  logic [IN_W-1:0] idx_r, idx_s;
  logic [IN_W-1:0] steps_r, steps_s;
  logic            done_r, done_s;
  logic            expire_s;

  dec_hold_timer u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_s && bus.sweep),
    .enable   (bus.en && (state_r == SWEEP)),
    .load_val (HOLD_LD),
    .expire   (expire_s)
  );

  assign bus.in_ready = ready_r && (state_r != SWEEP);
  assign bus.busy     = (state_r == SWEEP);
  assign bus.done     = done_r && bus.en;
`else
  assign bus.in_ready = ready_r;
  assign bus.busy     = 1'b0;
  assign bus.done     = 1'b0;
`endif

  assign accept_s      = bus.in_valid && bus.in_ready && bus.en;
  assign bus.out       = bus.en ? out_r : {OUT_W{1'b0}};
  assign bus.out_valid = bus.en && (state_r != IDLE);

  // Next-state and next-output logic; everything holds while en is low
  always_comb begin
    state_s = state_r;
    out_s   = out_r;
`ifdef DEC_SEQ_SWEEP_EN
    idx_s   = idx_r;
    steps_s = steps_r;
    done_s  = 1'b0;
`endif
    if (!bus.en) begin
      state_s = state_r;
    end else begin
      case (state_r)
        IDLE, HOLD: begin
          if (accept_s) begin
            out_s = ONE << bus.in;
`ifdef DEC_SEQ_SWEEP_EN
            idx_s   = bus.in;
            steps_s = {IN_W{1'b0}};
            state_s = bus.sweep ? SWEEP : HOLD;
`else
            state_s = HOLD;
`endif
          end else begin
            state_s = state_r;
          end
        end
`ifdef DEC_SEQ_SWEEP_EN
        SWEEP: begin
          if (expire_s) begin
            if (steps_r == LAST) begin
              state_s = IDLE;
              out_s   = {OUT_W{1'b0}};
              idx_s   = {IN_W{1'b0}};
              steps_s = {IN_W{1'b0}};
              done_s  = 1'b1;
            end else begin
              // idx wraps naturally from OUT_W-1 back to 0
              idx_s   = idx_r + IN_W'(1);
              steps_s = steps_r + IN_W'(1);
              out_s   = ONE << idx_s;
            end
          end else begin
            state_s = state_r;
          end
        end
`endif
        default: begin
          state_s = IDLE;
          out_s   = {OUT_W{1'b0}};
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      out_r   <= {OUT_W{1'b0}};
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      out_r   <= out_s;
      ready_r <= 1'b1;
    end
  end

`ifdef DEC_SEQ_SWEEP_EN
  // Sweep position, step count and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r   <= {IN_W{1'b0}};
      steps_r <= {IN_W{1'b0}};
      done_r  <= 1'b0;
    end else begin
      idx_r   <= idx_s;
      steps_r <= steps_s;
      done_r  <= done_s;
    end
  end
`endif

endmodule

// File: tb/tb_dec_seq.sv
// Directed self-checking bench for dec_seq (IN_W=4, HOLD_CYC=2); covers both builds.
module tb_dec_seq;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  dec_seq_if #(.IN_W(4)) bus ();

  dec_seq #(.IN_W(4), .HOLD_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus.en       = 1'b1;
    bus.in_valid = 1'b0;
    bus.in       = 4'd0;
    bus.sweep    = 1'b0;

    tick();
    tick();
    check_eq("rst_ready", {31'd0, bus.in_ready}, 32'd0);
    check_eq("rst_out", {16'd0, bus.out}, 32'd0);
    check_eq("rst_oval", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_done", {31'd0, bus.done}, 32'd0);

    rst = 1'b0;
    tick();
    check_eq("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check_eq("idle_oval", {31'd0, bus.out_valid}, 32'd0);

    // Direct decodes
    bus.in_valid = 1'b1; bus.sweep = 1'b0; bus.in = 4'd5;
    tick();
    bus.in_valid = 1'b0;
    #1;
    check_eq("dir5_out", {16'd0, bus.out}, 32'h0020);
    check_eq("dir5_oval", {31'd0, bus.out_valid}, 32'd1);
    tick();
    check_eq("dir5_hold", {16'd0, bus.out}, 32'h0020);
    check_eq("dir5_ready", {31'd0, bus.in_ready}, 32'd1);

    bus.in_valid = 1'b1; bus.in = 4'd15;
    tick();
    bus.in_valid = 1'b0;
    #1;
    check_eq("dir15_out", {16'd0, bus.out}, 32'h8000);

    bus.in_valid = 1'b1; bus.in = 4'd0;
    tick();
    bus.in_valid = 1'b0;
    #1;
    check_eq("dir0_out", {16'd0, bus.out}, 32'h0001);

    // en low blanks outputs and blocks acceptance
    bus.en = 1'b0; bus.in_valid = 1'b1; bus.in = 4'd3;
    #1;
    check_eq("en0_out", {16'd0, bus.out}, 32'd0);
    check_eq("en0_oval", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check_eq("en0_out2", {16'd0, bus.out}, 32'd0);
    bus.in_valid = 1'b0; bus.en = 1'b1;
    #1;
    check_eq("en1_restore", {16'd0, bus.out}, 32'h0001);
    check_eq("en1_oval", {31'd0, bus.out_valid}, 32'd1);

`ifdef DEC_SEQ_SWEEP_EN
    // Full sweep from 14 with in_valid held high throughout
    bus.in_valid = 1'b1; bus.sweep = 1'b1; bus.in = 4'd14;
    tick();
    bus.sweep = 1'b0; bus.in = 4'd5;
    #1;
    check_eq("sw_ready_low", {31'd0, bus.in_ready}, 32'd0);
    for (int p = 0; p < 16; p++) begin
      for (int h = 0; h < 2; h++) begin
        check_eq($sformatf("sw_out_p%0d_h%0d", p, h), {16'd0, bus.out}, 32'd1 << ((14 + p) % 16));
        check_eq($sformatf("sw_busy_p%0d_h%0d", p, h), {31'd0, bus.busy}, 32'd1);
        check_eq($sformatf("sw_done_p%0d_h%0d", p, h), {31'd0, bus.done}, 32'd0);
        tick();
      end
    end
    check_eq("sw_end_out", {16'd0, bus.out}, 32'd0);
    check_eq("sw_end_done", {31'd0, bus.done}, 32'd1);
    check_eq("sw_end_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("sw_end_oval", {31'd0, bus.out_valid}, 32'd0);
    check_eq("sw_end_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    check_eq("sw_after_done", {31'd0, bus.done}, 32'd0);
    check_eq("sw_accept_after", {16'd0, bus.out}, 32'h0020);

    // Freeze mid-sweep: position and remaining hold survive
    bus.in_valid = 1'b1; bus.sweep = 1'b1; bus.in = 4'd0;
    tick();
    bus.in_valid = 1'b0; bus.sweep = 1'b0;
    tick();
    check_eq("frz_pre", {16'd0, bus.out}, 32'h0001);
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("frz_out_%0d", i), {16'd0, bus.out}, 32'd0);
      check_eq($sformatf("frz_busy_%0d", i), {31'd0, bus.busy}, 32'd1);
      tick();
    end
    bus.en = 1'b1;
    #1;
    check_eq("frz_resume", {16'd0, bus.out}, 32'h0001);
    tick();
    check_eq("frz_adv1", {16'd0, bus.out}, 32'h0002);
    tick();
    check_eq("frz_hold1", {16'd0, bus.out}, 32'h0002);
    tick();
    check_eq("frz_adv2", {16'd0, bus.out}, 32'h0004);

    // Reset mid-sweep between edges
    rst = 1'b1;
    #1;
    check_eq("mrst_out", {16'd0, bus.out}, 32'd0);
    check_eq("mrst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("mrst_ready", {31'd0, bus.in_ready}, 32'd0);
    check_eq("mrst_done", {31'd0, bus.done}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("mrst_rel_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check_eq("mrst_edge_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      check_eq($sformatf("mrst_nodone_%0d", i), {31'd0, bus.done | bus.busy}, 32'd0);
      tick();
    end
`else
    // Sweep input ignored: treated as direct
    bus.in_valid = 1'b1; bus.sweep = 1'b1; bus.in = 4'd3;
    tick();
    bus.in_valid = 1'b0; bus.sweep = 1'b0;
    #1;
    check_eq("nosw_out", {16'd0, bus.out}, 32'h0008);
    check_eq("nosw_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("nosw_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq($sformatf("nosw_hold_%0d", i), {16'd0, bus.out}, 32'h0008);
      check_eq($sformatf("nosw_done_%0d", i), {31'd0, bus.done}, 32'd0);
    end

    // Reset between edges clears the held code
    rst = 1'b1;
    #1;
    check_eq("nrst_out", {16'd0, bus.out}, 32'd0);
    check_eq("nrst_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("nrst_edge_ready", {31'd0, bus.in_ready}, 32'd1);
    check_eq("nrst_oval", {31'd0, bus.out_valid}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
